// File: rtl/pdm_pkg.sv
// pdm_pkg: constants and width helpers shared by the PDM front-end blocks.
// PDM_MID is the offset-binary midscale common to the PDM demodulator and
// the CIC decimator outputs.
package pdm_pkg;

   localparam logic [31:0] PDM_MID = 32'h8000_0000;

   // Floor of log2 for a positive value; exact for powers of two.
   function automatic int unsigned pdm_log2(input int unsigned value);
      int unsigned result;
      result = 32'd0;
      for (int unsigned i = 32'd0; i < 32'd32; i++) begin
         if ((value >> i) > 32'd1) begin
            result = i + 32'd1;
         end
      end
      return result;
   endfunction

   // CIC register width: ORDER*log2(RATE) bits of growth, one sign bit and
   // one extra bit so that the full-scale comb result +RATE^ORDER is representable.
   function automatic int unsigned pdm_gw(input int unsigned order, input int unsigned rate);
      return order * pdm_log2(rate) + 32'd2;
   endfunction

endpackage

// File: rtl/pdm_ock_edge.sv
// pdm_ock_edge: two-flop synchronizer for the PDM bit clock plus a one-cycle
// edge strobe. FALLING selects which edge the strobe marks, so the other PDM
// blocks can reuse this for either sampling polarity.
module pdm_ock_edge #(
   parameter bit FALLING = 1'b0
) (
   input  logic clk,
   input  logic rstn,
   input  logic ock_i,
   output logic stb_o
);

   logic ock_d_q;
   logic ock_dd_q;

   // Synchronize ock into the clk domain; only rstn clears it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ock_d_q  <= 1'b0;
         ock_dd_q <= 1'b0;
      end else begin
         ock_d_q  <= ock_i;
         ock_dd_q <= ock_d_q;
      end
   end

   if (FALLING) begin : g_fall
      assign stb_o = ~ock_d_q & ock_dd_q;
   end else begin : g_rise
      assign stb_o = ock_d_q & ~ock_dd_q;
   end

endmodule

// File: rtl/pdm_cic_decimator.sv
// pdm_cic_decimator: 1-bit PDM to offset-binary PCM through an ORDER-stage
// CIC decimator of ratio RATE, with a valid/ready output register.
// Optional feature macro: PDM_CIC_OVR_CNT_EN adds the saturating 16-bit
// overrun counter port ovr_cnt (cleared only by rstn).
module pdm_cic_decimator
   import pdm_pkg::*;
#(
   parameter int ORDER = 4,
   parameter int RATE  = 64,
   parameter int OW    = 32
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          en,
   input  logic          ock,
   input  logic          sdi,
   output logic [OW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready
`ifdef PDM_CIC_OVR_CNT_EN
   ,
   output logic [15:0]   ovr_cnt
`endif
);

   localparam int LR  = int'(pdm_log2(RATE));
   localparam int GW  = int'(pdm_gw(ORDER, RATE));
   localparam int SW  = ORDER * LR + 1;   // saturated sample width
   localparam int PAD = OW - SW;          // zero LSBs after left-justify

   localparam logic signed [GW-1:0] PLUS_ONE   = {{(GW-1){1'b0}}, 1'b1};
   localparam logic signed [GW-1:0] MINUS_ONE  = {GW{1'b1}};
   localparam logic [LR-1:0]        PHASE_ONE  = LR'(1);
   localparam logic [2:0]           SETTLE_MAX = 3'(ORDER);
   localparam logic [OW-1:0]        MID_OW     = {PDM_MID[31], {(OW-1){1'b0}}};
   localparam logic [SW-1:0]        SAT_POS    = {1'b0, {(SW-1){1'b1}}};
   localparam logic [SW-1:0]        SAT_NEG    = {1'b1, {(SW-1){1'b0}}};

   logic                 bit_stb_s;
   logic signed [GW-1:0] bit_val_s;
   logic signed [GW-1:0] int_s [ORDER];
   logic signed [GW-1:0] cin_s [ORDER+1];
   logic signed [GW-1:0] comb_s;
   logic [SW-1:0]        sat_s;
   logic [OW-1:0]        just_s;
   logic [OW-1:0]        pcm_s;
   logic                 settled_s;
   logic                 load_s;
   logic                 blocked_s;

   logic [LR-1:0] phase_q, phase_d;
   logic          dec_stb_q, dec_stb_d;
   logic [2:0]    settle_q, settle_d;
   logic [OW-1:0] dout_q, dout_d;
   logic          valid_q, valid_d;

   pdm_ock_edge #(
      .FALLING (1'b0)
   ) u_ock_edge (
      .clk   (clk),
      .rstn  (rstn),
      .ock_i (ock),
      .stb_o (bit_stb_s)
   );

   assign bit_val_s = sdi ? PLUS_ONE : MINUS_ONE;

   // Integrator chain: stage k accumulates the previous-cycle value of stage k-1.
   for (genvar k = 0; k < ORDER; k++) begin : g_int
      logic signed [GW-1:0] acc_q, acc_d;
      logic signed [GW-1:0] addend_s;

      if (k == 0) begin : g_first
         assign addend_s = bit_val_s;
      end else begin : g_next
         assign addend_s = int_s[k-1];
      end

      // Next accumulator value: add on each bit strobe, wrap modulo 2^GW.
      always_comb begin
         acc_d = acc_q;
         if (!en) begin
            acc_d = '0;
         end else if (bit_stb_s) begin
            acc_d = acc_q + addend_s;
         end else begin
            acc_d = acc_q;
         end
      end

      // Integrator state register.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            acc_q <= '0;
         end else begin
            acc_q <= acc_d;
         end
      end

      assign int_s[k] = acc_q;
   end

   assign cin_s[0] = int_s[ORDER-1];

   // Comb chain: evaluated combinationally, delays capture inputs on dec_stb.
   for (genvar k = 0; k < ORDER; k++) begin : g_comb
      logic signed [GW-1:0] z_q, z_d;

      assign cin_s[k+1] = cin_s[k] - z_q;

      // Comb delay update on the decimation strobe.
      always_comb begin
         z_d = z_q;
         if (!en) begin
            z_d = '0;
         end else if (dec_stb_q) begin
            z_d = cin_s[k];
         end else begin
            z_d = z_q;
         end
      end

      // Comb delay register.
      always_ff @(posedge clk or negedge rstn) begin
         if (!rstn) begin
            z_q <= '0;
         end else begin
            z_q <= z_d;
         end
      end
   end

   assign comb_s = cin_s[ORDER];

   // Clamp to SW-bit signed; only +RATE^ORDER can actually overflow.
   always_comb begin
      sat_s = comb_s[SW-1:0];
      if (comb_s[GW-1] == comb_s[GW-2]) begin
         sat_s = comb_s[SW-1:0];
      end else if (!comb_s[GW-1]) begin
         sat_s = SAT_POS;
      end else begin
         sat_s = SAT_NEG;
      end
   end

   assign just_s = OW'(sat_s) << PAD;
   assign pcm_s  = just_s ^ MID_OW;

   assign settled_s = (settle_q == SETTLE_MAX);
   assign load_s    = dec_stb_q & settled_s;
   assign blocked_s = valid_q & ~dout_ready;

   // Phase, settling and output handshake next-state logic.
   always_comb begin
      phase_d   = phase_q;
      dec_stb_d = 1'b0;
      settle_d  = settle_q;
      dout_d    = dout_q;
      valid_d   = valid_q;
      if (!en) begin
         phase_d   = '0;
         dec_stb_d = 1'b0;
         settle_d  = 3'd0;
         dout_d    = MID_OW;
         valid_d   = 1'b0;
      end else begin
         if (bit_stb_s) begin
            phase_d   = phase_q + PHASE_ONE;
            dec_stb_d = &phase_q;
         end else begin
            phase_d   = phase_q;
            dec_stb_d = 1'b0;
         end

         if (dec_stb_q && !settled_s) begin
            settle_d = settle_q + 3'd1;
         end else begin
            settle_d = settle_q;
         end

         if (load_s && !blocked_s) begin
            dout_d  = pcm_s;
            valid_d = 1'b1;
         end else if (load_s) begin
            dout_d  = dout_q;
            valid_d = valid_q;
         end else if (valid_q && dout_ready) begin
            dout_d  = dout_q;
            valid_d = 1'b0;
         end else begin
            dout_d  = dout_q;
            valid_d = valid_q;
         end
      end
   end

   // Control and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         phase_q   <= '0;
         dec_stb_q <= 1'b0;
         settle_q  <= 3'd0;
         dout_q    <= MID_OW;
         valid_q   <= 1'b0;
      end else begin
         phase_q   <= phase_d;
         dec_stb_q <= dec_stb_d;
         settle_q  <= settle_d;
         dout_q    <= dout_d;
         valid_q   <= valid_d;
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;

`ifdef PDM_CIC_OVR_CNT_EN
   logic [15:0] ovr_q, ovr_d;
   logic        overrun_s;

   assign overrun_s = en & load_s & blocked_s;

   // Saturating count of samples dropped because the consumer stalled.
   always_comb begin
      ovr_d = ovr_q;
      if (overrun_s && (ovr_q != 16'hFFFF)) begin
         ovr_d = ovr_q + 16'd1;
      end else begin
         ovr_d = ovr_q;
      end
   end

   // Overrun counter register; en does not clear it.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr_q <= 16'd0;
      end else begin
         ovr_q <= ovr_d;
      end
   end

   assign ovr_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// tb_pdm_cic_decimator: random PDM stimulus checked every cycle against a
// convolution-based CIC reference model with a valid/ready scoreboard.
module tb_pdm_cic_decimator;

   localparam int ORD = 4;
   localparam int RT  = 64;
   localparam int LRT = $clog2(RT);
   localparam int SWB = ORD * LRT + 1;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        en = 1'b1;
   logic        ock = 1'b0;
   logic        sdi = 1'b0;
   logic        dout_ready = 1'b1;
   logic [31:0] dout;
   logic        dout_valid;
`ifdef PDM_CIC_OVR_CNT_EN
   logic [15:0] ovr_cnt;
`endif

   pdm_cic_decimator #(.ORDER(ORD), .RATE(RT), .OW(32)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .en         (en),
      .ock        (ock),
      .sdi        (sdi),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef PDM_CIC_OVR_CNT_EN
      ,
      .ovr_cnt    (ovr_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   bit checking = 1'b0;
   int rdy_mode = 0;   // 0 always ready, 1 stalled, 2 random, 3 ready only on load

   // reference model state
   longint h[$];
   int     hist[$];
   int     stb_cyc_q[$];
   bit     stb_bit_q[$];
   int     cyc = 0;
   int     nbits = 0;
   int     settle = 0;
   int     dec_cycle = -1;
   logic [31:0] exp_dout = 32'h8000_0000;
   bit     exp_valid = 1'b0;
   int     exp_ovr = 0;
   int     sim_loads = 0;
   bit     armed = 1'b1;

   task automatic check(input string name, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Impulse response of ORD cascaded length-RT moving sums.
   task automatic build_h();
      longint nh[$];
      h.delete();
      h.push_back(64'sd1);
      for (int s = 0; s < ORD; s++) begin
         nh.delete();
         for (int n = 0; n < h.size() + RT - 1; n++) begin
            longint acc = 0;
            for (int j = 0; j < RT; j++) begin
               if (n - j >= 0 && n - j < h.size()) acc += h[n - j];
            end
            nh.push_back(acc);
         end
         h = nh;
      end
   endtask

   // Filter output after nbits inputs; pipelined integrators add ORD-1 bits of delay.
   function automatic longint cic_out();
      longint y = 0;
      for (int j = 0; j < h.size(); j++) begin
         int i = nbits - (ORD - 1) - j;
         if (i >= 1) y += h[j] * hist[i - 1];
      end
      return y;
   endfunction

   function automatic logic [31:0] to_pcm(input longint y);
      longint lim = longint'(1) << (SWB - 1);
      longint v;
      if (y > lim - 1) y = lim - 1;
      if (y < -lim) y = -lim;
      v = y * (longint'(1) << (32 - SWB)) + 64'sd2147483648;
      return v[31:0];
   endfunction

   task automatic model_clear();
      hist.delete();
      nbits = 0;
      settle = 0;
      dec_cycle = -1;
      exp_dout = 32'h8000_0000;
      exp_valid = 1'b0;
      armed = 1'b1;
   endtask

   // Reference model: bit arrivals, decimation, settling and handshake.
   always @(posedge clk or negedge rstn) begin : model
      bit load;
      logic [31:0] val;
      if (!rstn) begin
         model_clear();
         exp_ovr = 0;
         stb_cyc_q.delete();
         stb_bit_q.delete();
      end else begin
         cyc++;
         if (!en) begin
            model_clear();
            if (stb_cyc_q.size() > 0 && stb_cyc_q[0] == cyc) begin
               void'(stb_cyc_q.pop_front());
               void'(stb_bit_q.pop_front());
            end
         end else begin
            load = 1'b0;
            val = 32'h0;
            if (dec_cycle == cyc) begin
               dec_cycle = -1;
               if (settle < ORD) settle++;
               else begin
                  load = 1'b1;
                  val = to_pcm(cic_out());
               end
            end
            if (load) begin
               if (exp_valid && !dout_ready) begin
                  if (exp_ovr < 65535) exp_ovr++;
               end else begin
                  if (exp_valid && dout_ready) sim_loads++;
                  exp_dout = val;
                  exp_valid = 1'b1;
               end
            end else if (exp_valid && dout_ready) begin
               exp_valid = 1'b0;
            end
            if (stb_cyc_q.size() > 0 && stb_cyc_q[0] == cyc) begin
               void'(stb_cyc_q.pop_front());
               hist.push_back(stb_bit_q.pop_front() ? 1 : -1);
               nbits++;
               if (nbits % RT == 0) dec_cycle = cyc + 1;
            end
         end
      end
   end

   // Consumer ready generator.
   always @(negedge clk) begin
      case (rdy_mode)
         0: dout_ready = 1'b1;
         1: dout_ready = 1'b0;
         2: dout_ready = 1'($urandom_range(0, 1));
         3: dout_ready = (dec_cycle == cyc + 1);
         default: dout_ready = 1'b1;
      endcase
   end

   // Per-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (checking) begin
         n_chk++;
         if (dout !== exp_dout) begin
            n_fail++;
            $display("FAIL cmp_dout cyc=%0d: got 0x%08h expected 0x%08h", cyc, dout, exp_dout);
         end
         n_chk++;
         if (dout_valid !== exp_valid) begin
            n_fail++;
            $display("FAIL cmp_valid cyc=%0d: got %0b expected %0b", cyc, dout_valid, exp_valid);
         end
`ifdef PDM_CIC_OVR_CNT_EN
         n_chk++;
         if (ovr_cnt !== 16'(exp_ovr)) begin
            n_fail++;
            $display("FAIL cmp_ovr cyc=%0d: got %0d expected %0d", cyc, ovr_cnt, exp_ovr);
         end
`endif
         if (armed && dout_valid === 1'b1) begin
            armed = 1'b0;
            n_chk++;
            if (nbits < (ORD + 1) * RT) begin
               n_fail++;
               $display("FAIL first_valid_latency: got %0d bits expected >= %0d", nbits, (ORD + 1) * RT);
            end
         end
      end
   end

   task automatic send_bit(input bit b);
      int hi;
      int lo;
      hi = $urandom_range(2, 3);
      lo = $urandom_range(2, 3);
      @(negedge clk);
      ock = 1'b1;
      sdi = b;
      stb_cyc_q.push_back(cyc + 2);
      stb_bit_q.push_back(b);
      repeat (hi) @(negedge clk);
      ock = 1'b0;
      repeat (lo - 1) @(negedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin : main
      int ovr0;
      int sim0;
      build_h();
      check("h_first_tap", h[0], 1);
      begin
         longint s = 0;
         foreach (h[i]) s += h[i];
         check("h_dc_gain", s, longint'(1) << (ORD * LRT));
      end
      check("model_full_scale", to_pcm(longint'(1) << (ORD * LRT)), 32'hFFFF_FF80);

      idle(3);
      check("rst_dout", dout, 32'h8000_0000);
      check("rst_valid", dout_valid, 0);
      @(posedge clk);
      #1 rstn = 1'b1;
      checking = 1'b1;

      // constant ones
      repeat (8 * RT) send_bit(1'b1);
      idle(4);
      check("ones_dout", dout, 32'hFFFF_FF80);
      check("ones_model", exp_dout, 32'hFFFF_FF80);

      // backpressure over three decimation periods
      ovr0 = exp_ovr;
      rdy_mode = 1;
      repeat (3 * RT) send_bit(1'($urandom_range(0, 1)));
      idle(4);
      check("bp_model_ovr", exp_ovr - ovr0, 2);
      check("bp_valid_held", dout_valid, 1);
`ifdef PDM_CIC_OVR_CNT_EN
      check("bp_ovr_cnt", ovr_cnt, 2);
`endif
      rdy_mode = 0;
      idle(4);
      check("bp_release_valid", dout_valid, 0);

      // one-cycle enable drop
      @(negedge clk);
      en = 1'b0;
      @(negedge clk);
      check("en_dout", dout, 32'h8000_0000);
      check("en_valid", dout_valid, 0);
      en = 1'b1;

      // constant zeros
      repeat (8 * RT) send_bit(1'b0);
      idle(4);
      check("zeros_dout", dout, 32'h0000_0000);

      // alternating pattern
      for (int i = 0; i < 8 * RT; i++) send_bit(1'(i % 2));
      idle(4);
      check("alt_dout", dout, 32'h8000_0000);
      check("alt_model", exp_dout, 32'h8000_0000);

      // ready asserted exactly on the load cycle
      sim0 = sim_loads;
      ovr0 = exp_ovr;
      rdy_mode = 3;
      repeat (6 * RT) send_bit(1'($urandom_range(0, 1)));
      idle(4);
      check("simul_loads", sim_loads - sim0, 5);
      check("simul_no_ovr", exp_ovr - ovr0, 0);
      check("simul_valid", dout_valid, 1);

      // random data with random ready
      rdy_mode = 2;
      repeat (30 * RT) send_bit(1'($urandom_range(0, 1)));

      // mid-stream reset with a pending sample
      rdy_mode = 1;
      repeat (2 * RT) send_bit(1'($urandom_range(0, 1)));
      idle(3);
      check("pre_rst_valid", dout_valid, 1);
      @(posedge clk);
      #1 rstn = 1'b0;
      #1;
      check("midrst_dout", dout, 32'h8000_0000);
      check("midrst_valid", dout_valid, 0);
`ifdef PDM_CIC_OVR_CNT_EN
      check("midrst_ovr", ovr_cnt, 0);
`endif
      idle(2);
      @(posedge clk);
      #1 rstn = 1'b1;
      rdy_mode = 0;
      repeat (6 * RT) send_bit(1'($urandom_range(0, 1)));
      idle(4);
      check("post_rst_output_seen", armed, 0);

      idle(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
